// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-address generator.
// Holds the FSM state encoding, the default reset address and the alignment-mask helper.
// Optional trap redirect path is enabled by defining PC_TRAP_EN (left undefined by default):
// `define PC_TRAP_EN
package pc_gen_pkg;

    // Fetch-address generator states
    typedef enum logic [1:0] {
        PCG_IDLE  = 2'd0,
        PCG_RUN   = 2'd1,
        PCG_HOLD  = 2'd2,
        PCG_REDIR = 2'd3
    } pcg_state_t;

    // Default value of pc_o during and immediately after reset
    localparam logic [31:0] PC_START_ADDR = 32'h0000_0000;

    // Low address bits that must be zero for a legal fetch target at the given step size
    function automatic logic [1:0] low_mask(input int step);
        return (step == 2) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: trap/jump priority select, target alignment, misalign detect, pending target.
// Latency: select/align is combinational; a pending target is held one or more cycles until fire.
// Backpressure: a redirect arriving while a request is outstanding is parked until the request fires.
// Trap input exists only when PC_TRAP_EN is defined.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
`ifdef PC_TRAP_EN
    input  logic              trap_en,
    input  logic [ADDR_W-1:0] trap_addr,
`endif
    input  logic              outstanding,
    input  logic              fire,
    output logic              redir,
    output logic              pend_vld,
    output logic [ADDR_W-1:0] apply_addr,
    output logic              apply_mis
);

    localparam logic [ADDR_W-1:0] LOW_MASK = {{(ADDR_W-2){1'b0}}, low_mask(STEP)};

    logic              req;
    logic [ADDR_W-1:0] raw_addr;
    logic [ADDR_W-1:0] new_addr;
    logic              new_mis;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_mis;

    // Pick the highest-priority redirect request this cycle (trap beats jump)
    always_comb begin
        req      = jump_en;
        raw_addr = jump_addr;
`ifdef PC_TRAP_EN
        if (trap_en) begin
            req      = 1'b1;
            raw_addr = trap_addr;
        end
`endif
    end

    assign new_addr = raw_addr & ~LOW_MASK;
    assign new_mis  = |(raw_addr & LOW_MASK);

    // Park the latest redirect while a request waits; drop it once that request fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_mis  <= 1'b0;
        end else if (req && outstanding) begin
            pend_vld  <= 1'b1;
            pend_addr <= new_addr;
            pend_mis  <= new_mis;
        end else if (fire) begin
            pend_vld  <= 1'b0;
        end
    end

    // A fresh redirect always supersedes a parked one
    assign redir      = req;
    assign apply_addr = req ? new_addr : pend_addr;
    assign apply_mis  = req ? new_mis  : pend_mis;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: drives pc_o to instruction memory with epoch tagging on redirects.
// Latency: req_valid_o rises one cycle after reset release; one address per cycle while ready.
// Backpressure: pc_o/req_valid_o hold while ready is low; stall only blocks new requests.
// Optional trap redirect ports exist only when PC_TRAP_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_START_ADDR),
    parameter int                STEP       = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
`ifdef PC_TRAP_EN
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
`endif
    input  logic              stall_i,
    input  logic              req_ready_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              epoch_o,
    output logic              misalign_o
);

    pcg_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              epoch_nxt;
    logic              mis_nxt;
    logic              fire;
    logic              outstanding;
    logic              apply;
    logic              redir;
    logic              pend_vld;
    logic [ADDR_W-1:0] apply_addr;
    logic              apply_mis;

    assign req_valid_o = (state == PCG_RUN) || (state == PCG_REDIR);
    assign fire        = req_valid_o && req_ready_i;
    assign outstanding = req_valid_o && !req_ready_i;

    // A redirect takes effect only when no request is waiting on the memory
    assign apply = !outstanding && (redir || (fire && pend_vld));

    pc_redirect_arb #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_arb (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .jump_en     (jump_en_i),
        .jump_addr   (jump_addr_i),
`ifdef PC_TRAP_EN
        .trap_en     (trap_en_i),
        .trap_addr   (trap_addr_i),
`endif
        .outstanding (outstanding),
        .fire        (fire),
        .redir       (redir),
        .pend_vld    (pend_vld),
        .apply_addr  (apply_addr),
        .apply_mis   (apply_mis)
    );

    // Next state, next pc, epoch toggle and misalign pulse
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_o;
        epoch_nxt = epoch_o ^ apply;
        mis_nxt   = apply && apply_mis;

        if (apply) begin
            pc_nxt = apply_addr;
        end else if (fire) begin
            pc_nxt = pc_o + ADDR_W'(STEP);
        end

        case (state)
            PCG_IDLE:  state_nxt = PCG_RUN;
            PCG_RUN: begin
                if (outstanding) begin
                    state_nxt = redir ? PCG_REDIR : PCG_RUN;
                end else begin
                    state_nxt = stall_i ? PCG_HOLD : PCG_RUN;
                end
            end
            PCG_HOLD:  state_nxt = stall_i ? PCG_HOLD : PCG_RUN;
            PCG_REDIR: begin
                if (!outstanding) begin
                    state_nxt = stall_i ? PCG_HOLD : PCG_RUN;
                end
            end
            default:   state_nxt = PCG_IDLE;
        endcase
    end

    // State, pc, epoch and misalign registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= PCG_IDLE;
            pc_o       <= RESET_ADDR;
            epoch_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_o       <= pc_nxt;
            epoch_o    <= epoch_nxt;
            misalign_o <= mis_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a reference model.
// Outputs are compared 1 time unit after every rising edge.
// Trap scenarios run only when PC_TRAP_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
`ifdef PC_TRAP_EN
    logic        trap_en;
    logic [31:0] trap_addr;
`endif
    logic        stall;
    logic        ready;
    logic        valid;
    logic [31:0] pc;
    logic        epoch;
    logic        mis;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: what fetch should look like after the next edge
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_epoch;
    logic        m_mis;
    logic        m_started;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_pend_mis;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
`ifdef PC_TRAP_EN
        .trap_en_i   (trap_en),
        .trap_addr_i (trap_addr),
`endif
        .stall_i     (stall),
        .req_ready_i (ready),
        .req_valid_o (valid),
        .pc_o        (pc),
        .epoch_o     (epoch),
        .misalign_o  (mis)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'h0;
        m_valid    = 1'b0;
        m_epoch    = 1'b0;
        m_mis      = 1'b0;
        m_started  = 1'b0;
        m_pend_v   = 1'b0;
        m_pend     = 32'h0;
        m_pend_mis = 1'b0;
    endtask

    task automatic drive(input logic j, input logic [31:0] a, input logic s, input logic r);
        jump_en   = j;
        jump_addr = a;
        stall     = s;
        ready     = r;
    endtask

    // Advance the model by one edge from the applied inputs, clock the DUT, then compare
    task automatic step(input string tag);
        logic        redir;
        logic [31:0] raw;
        logic [31:0] tgt;
        logic        tmis;
        redir = jump_en;
        raw   = jump_addr;
`ifdef PC_TRAP_EN
        if (trap_en) begin
            redir = 1'b1;
            raw   = trap_addr;
        end
`endif
        tgt   = {raw[31:2], 2'b00};
        tmis  = (raw[1:0] != 2'b00);
        m_mis = 1'b0;
        if (m_valid && !ready) begin
            // request waits: only the parked target can change, last one wins
            if (redir) begin
                m_pend_v   = 1'b1;
                m_pend     = tgt;
                m_pend_mis = tmis;
            end
        end else begin
            if (redir) begin
                m_pc    = tgt;
                m_epoch = ~m_epoch;
                m_mis   = tmis;
            end else if (m_pend_v) begin
                m_pc    = m_pend;
                m_epoch = ~m_epoch;
                m_mis   = m_pend_mis;
            end else if (m_valid) begin
                m_pc = m_pc + 32'd4;
            end
            m_pend_v  = 1'b0;
            m_valid   = m_started ? !stall : 1'b1;
            m_started = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"},    pc,           m_pc);
        check({tag, ".valid"}, 32'(valid),   32'(m_valid));
        check({tag, ".epoch"}, 32'(epoch),   32'(m_epoch));
        check({tag, ".mis"},   32'(mis),     32'(m_mis));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".pc"},    pc,         32'h0);
        check({tag, ".valid"}, 32'(valid), 32'h0);
        check({tag, ".epoch"}, 32'(epoch), 32'h0);
        check({tag, ".mis"},   32'(mis),   32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef PC_TRAP_EN
        trap_en   = 1'b0;
        trap_addr = 32'h0;
`endif
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first request one cycle after release, then sequential addresses
        step("t1_first");
        check("t1_first_pc", pc, 32'h0);
        check("t1_first_valid", 32'(valid), 32'h1);
        step("t1_a");
        step("t1_b");
        check("t1_pc8", pc, 32'h8);
        step("t1_c");
        step("t1_d");

        // 2: outstanding request at 0x10 held for 3 cycles
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("t2_hold");
            check("t2_hold_pc", pc, 32'h10);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t2_release");
        check("t2_pc14", pc, 32'h14);

        // 3: jump while a request is outstanding, then an overwritten pending target
        step("t3_a");
        step("t3_b");
        step("t3_c");
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        step("t3_park");
        check("t3_park_pc", pc, 32'h20);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("t3_wait");
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t3_fire");
        check("t3_pc200", pc, 32'h200);
        check("t3_epoch", 32'(epoch), 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("t3_w2");
        drive(1'b1, 32'h250, 1'b0, 1'b0);
        step("t3_park2");
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step("t3_park3");
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t3_fire2");
        check("t3_pc300", pc, 32'h300);
        check("t3_epoch2", 32'(epoch), 32'h0);

        // 4: stall at fire, jump during stall, resume
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step("t4_stall");
        check("t4_stall_valid", 32'(valid), 32'h0);
        check("t4_stall_pc", pc, 32'h304);
        drive(1'b1, 32'h80, 1'b1, 1'b1);
        step("t4_jump");
        check("t4_pc80", pc, 32'h80);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step("t4_still");
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t4_resume");
        check("t4_resume_valid", 32'(valid), 32'h1);
        step("t4_next");

        // 5: trap priority and misaligned target
`ifdef PC_TRAP_EN
        trap_en   = 1'b1;
        trap_addr = 32'h1000;
        drive(1'b1, 32'h2000, 1'b0, 1'b1);
        step("t5_trap");
        check("t5_trap_pc", pc, 32'h1000);
        trap_en = 1'b0;
`endif
        drive(1'b1, 32'h103, 1'b0, 1'b1);
        step("t5_mis");
        check("t5_mis_pc", pc, 32'h100);
        check("t5_mis_pulse", 32'(mis), 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t5_mis_end");
        check("t5_mis_clear", 32'(mis), 32'h0);

        // 6: address wrap
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        step("t6_top");
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("t6_wrap");
        check("t6_wrap_pc", pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 5) == 0), $urandom_range(0, 32'hFFF),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
`ifdef PC_TRAP_EN
            trap_en   = ($urandom_range(0, 9) == 0);
            trap_addr = $urandom_range(32'h1000, 32'h1FFF);
`endif
            step("rnd");
        end
`ifdef PC_TRAP_EN
        trap_en = 1'b0;
`endif

        // 6b: reset asserted while a redirect is parked
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4 && !m_valid; i++) step("t6_fill");
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        step("t6_park");
        check("t6_parked_valid", 32'(valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async_rst");
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_restart");
        check("t6_restart_pc", pc, 32'h0);
        check("t6_restart_epoch", 32'(epoch), 32'h0);
        step("t6_after");
        check("t6_after_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
